// File: rtl/apb_reg_bank.sv
// apb_reg_bank: APB4 slave register bank; APB (PSEL/PENABLE/PWRITE/PADDR/PWDATA/PSTRB -> PRDATA/PREADY/PSLVERR), busy write-block in, flat regs out, start pulse out
module apb_reg_bank #(
  parameter int AMBA_WORD       = 32,
  parameter int AMBA_ADDR_WIDTH = 20,
  parameter int NUM_REGS        = 4,
  parameter int WAIT_STATES     = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          PSEL,
  input  logic                          PENABLE,
  input  logic                          PWRITE,
  input  logic [AMBA_ADDR_WIDTH-1:0]    PADDR,
  input  logic [AMBA_WORD-1:0]          PWDATA,
  input  logic [AMBA_WORD/8-1:0]        PSTRB,
  output logic [AMBA_WORD-1:0]          PRDATA,
  output logic                          PREADY,
  output logic                          PSLVERR,
  input  logic                          busy,
  output logic [NUM_REGS*AMBA_WORD-1:0] regs,
  output logic                          start
);
  localparam int NB = AMBA_WORD / 8;
  typedef enum logic {IDLE, ACCESS} state_t;
  state_t                        state_q, state_d;
  logic [3:0]                    wait_q, wait_d;
  logic [NUM_REGS*AMBA_WORD-1:0] regs_q, regs_d;
  logic                          start_q, start_d;
  logic [3:0]                    idx;
  logic                          addr_err, commit;
  assign idx      = PADDR[5:2];
  assign addr_err = (PADDR[1:0] != 2'b00) || (PADDR >= AMBA_ADDR_WIDTH'(4 * NUM_REGS));
  assign PREADY   = (state_q == ACCESS) && PSEL && PENABLE && (wait_q == 4'(WAIT_STATES));
  assign PSLVERR  = PREADY && (addr_err || (PWRITE && busy));
  assign commit   = PREADY && PWRITE && !addr_err && !busy;
  assign start_d  = commit && (idx == 4'd0) && PSTRB[0] && PWDATA[0];
  assign regs     = regs_q;
  assign start    = start_q;
  always_comb begin
    PRDATA = '0;
    for (int i = 0; i < NUM_REGS; i++)
      if (PREADY && !PWRITE && !addr_err && idx == 4'(i)) PRDATA = regs_q[i*AMBA_WORD +: AMBA_WORD];
  end
  always_comb begin
    regs_d = regs_q;
    for (int i = 0; i < NUM_REGS; i++)
      for (int b = 0; b < NB; b++)
        if (commit && idx == 4'(i) && PSTRB[b]) regs_d[i*AMBA_WORD + b*8 +: 8] = PWDATA[b*8 +: 8];
  end
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    if (state_q == IDLE) begin
      wait_d = '0;
      if (PSEL && !PENABLE) state_d = ACCESS;
    end else if (!PSEL || !PENABLE || PREADY) begin
      state_d = IDLE;
      wait_d  = '0;
    end else if (wait_q < 4'(WAIT_STATES)) begin
      wait_d = wait_q + 4'd1;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      wait_q  <= '0;
      regs_q  <= '0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      regs_q  <= regs_d;
      start_q <= start_d;
    end
  end
endmodule

// File: tb/tb_apb_reg_bank.sv
// tb_apb_reg_bank: randomized APB traffic on three banks (0/3/2 wait states) checked every cycle against a register-array model
module tb_apb_reg_bank;
  logic        clk = 0;
  logic        rst = 1;
  logic        psel[3], penable[3], pwrite[3], busy[3];
  logic [19:0] paddr[3];
  logic [31:0] pwdata[3];
  logic [3:0]  pstrb[3];
  logic [31:0] prdata[3];
  logic        pready[3], pslverr[3], start[3];
  logic [127:0] regs[3];
  int          ws[3] = '{0, 3, 2};
  logic [31:0] m_regs[3][4];
  logic        e_ready[3], e_err[3], e_start[3];
  logic [31:0] e_rdata[3];
  bit          pc[3], pst[3];
  logic [1:0]  pi[3];
  logic [31:0] pd[3];
  logic [3:0]  ps[3];
  int          total = 0, bad = 0;
  bit          chk_en = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 3; g++) begin : g_dut
    apb_reg_bank #(.AMBA_WORD(32), .AMBA_ADDR_WIDTH(20), .NUM_REGS(4),
                   .WAIT_STATES(g == 0 ? 0 : (g == 1 ? 3 : 2))) u_dut (
      .clk(clk), .rst(rst), .PSEL(psel[g]), .PENABLE(penable[g]), .PWRITE(pwrite[g]),
      .PADDR(paddr[g]), .PWDATA(pwdata[g]), .PSTRB(pstrb[g]), .PRDATA(prdata[g]),
      .PREADY(pready[g]), .PSLVERR(pslverr[g]), .busy(busy[g]), .regs(regs[g]), .start(start[g]));
  end
  task automatic chk(input string n, input int k, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s dut%0d got=%h want=%h t=%0t", n, k, act, exp, $time);
    end
  endtask
  always @(negedge clk) if (chk_en) for (int k = 0; k < 3; k++) begin
    chk("pready", k, 32'(pready[k]), 32'(e_ready[k]));
    chk("pslverr", k, 32'(pslverr[k]), 32'(e_err[k]));
    chk("prdata", k, prdata[k], e_rdata[k]);
    chk("start", k, 32'(start[k]), 32'(e_start[k]));
    for (int r = 0; r < 4; r++) chk("regs", k, regs[k][r*32 +: 32], m_regs[k][r]);
  end
  task automatic step();
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      e_start[k] = 0;
      if (rst) begin
        for (int r = 0; r < 4; r++) m_regs[k][r] = '0;
        pc[k] = 0;
      end else if (pc[k]) begin
        for (int b = 0; b < 4; b++) if (ps[k][b]) m_regs[k][pi[k]][b*8 +: 8] = pd[k][b*8 +: 8];
        e_start[k] = pst[k];
        pc[k] = 0;
      end
      e_ready[k] = 0;
      e_err[k]   = 0;
      e_rdata[k] = '0;
      psel[k]    = 0;
      penable[k] = 0;
    end
  endtask
  task automatic xfer(input int k, input bit wr, input logic [19:0] a, input logic [31:0] d,
                      input logic [3:0] s, input bit b, input int ab,
                      output logic [31:0] rd, output logic er);
    bit aerr;
    rd = '0;
    er = 0;
    aerr = (a[1:0] != 2'b00) || (a >= 20'd16);
    step();
    psel[k] = 1; pwrite[k] = wr; paddr[k] = a; pwdata[k] = d; pstrb[k] = s;
    busy[k] = 1'($urandom);
    for (int c = 0; c <= ws[k]; c++) begin
      step();
      psel[k] = 1;
      penable[k] = 1;
      busy[k] = 1'($urandom);
      if (c == ab) begin
        penable[k] = 0;
        return;
      end
      if (c == ws[k]) begin
        busy[k]    = b;
        e_ready[k] = 1;
        e_err[k]   = aerr || (wr && b);
        e_rdata[k] = (!wr && !aerr) ? m_regs[k][a[3:2]] : '0;
        if (wr && !e_err[k]) begin
          pc[k] = 1; pi[k] = a[3:2]; pd[k] = d; ps[k] = s;
          pst[k] = (a[3:2] == 2'd0) && s[0] && d[0];
        end
        @(negedge clk);
        rd = prdata[k];
        er = pslverr[k];
      end
    end
  endtask
  initial begin
    logic [31:0] rd, d;
    logic        er;
    logic [19:0] a;
    logic [3:0]  s;
    int          k, sel, ab;
    bit          wr, b;
    for (int i = 0; i < 3; i++) begin
      psel[i] = 0; penable[i] = 0; pwrite[i] = 0; busy[i] = 0;
      paddr[i] = '0; pwdata[i] = '0; pstrb[i] = '0;
      e_ready[i] = 0; e_err[i] = 0; e_start[i] = 0; e_rdata[i] = '0; pc[i] = 0;
      for (int r = 0; r < 4; r++) m_regs[i][r] = '0;
    end
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 0;
    chk_en = 1;
    xfer(0, 1, 20'h4, 32'hA5A5_0003, 4'hF, 0, -1, rd, er);
    xfer(0, 0, 20'h4, 32'h0, 4'h0, 0, -1, rd, er);
    chk("lit_rd4", 0, rd, 32'hA5A5_0003);
    step();
    chk("lit_reg1", 0, regs[0][63:32], 32'hA5A5_0003);
    xfer(1, 1, 20'h0, 32'h1, 4'hF, 0, -1, rd, er);
    step();
    chk("lit_start_hi", 1, 32'(start[1]), 32'd1);
    chk("lit_ctrl", 1, regs[1][31:0], 32'h1);
    step();
    chk("lit_start_lo", 1, 32'(start[1]), 32'd0);
    xfer(0, 1, 20'h8, 32'hFFFF_FFFF, 4'hF, 0, -1, rd, er);
    xfer(0, 1, 20'h8, 32'h1234_5678, 4'b0101, 0, -1, rd, er);
    xfer(0, 0, 20'h8, 32'h0, 4'h0, 0, -1, rd, er);
    chk("lit_strb", 0, rd, 32'hFF34_FF78);
    xfer(0, 0, 20'h10, 32'h0, 4'hF, 0, -1, rd, er);
    chk("lit_oob_err", 0, 32'(er), 32'd1);
    chk("lit_oob_rd", 0, rd, 32'h0);
    xfer(0, 1, 20'h6, 32'hFFFF_FFFF, 4'hF, 0, -1, rd, er);
    chk("lit_mis_err", 0, 32'(er), 32'd1);
    step();
    chk("lit_mis_keep", 0, regs[0][63:32], 32'hA5A5_0003);
    xfer(0, 1, 20'hC, 32'h77, 4'hF, 0, -1, rd, er);
    xfer(0, 1, 20'hC, 32'hDEAD, 4'hF, 1, -1, rd, er);
    chk("lit_busy_err", 0, 32'(er), 32'd1);
    xfer(0, 0, 20'hC, 32'h0, 4'h0, 1, -1, rd, er);
    chk("lit_busy_rd_err", 0, 32'(er), 32'd0);
    chk("lit_busy_rd", 0, rd, 32'h77);
    xfer(0, 1, 20'h0, 32'h1, 4'h1, 0, -1, rd, er);
    xfer(0, 1, 20'h0, 32'h3, 4'h1, 0, -1, rd, er);
    for (int n = 0; n < 300; n++) begin
      k   = $urandom_range(0, 2);
      sel = $urandom_range(0, 9);
      a   = 20'(4 * $urandom_range(0, 3));
      if (sel == 0) a = 20'(4 * $urandom_range(4, 7));
      else if (sel == 1) a = a | 20'($urandom_range(1, 3));
      else if (sel == 2) a = 20'h80000;
      wr = 1'($urandom);
      d  = $urandom;
      if ($urandom_range(0, 2) == 0) d[0] = 1;
      s  = 4'($urandom);
      b  = ($urandom_range(0, 3) == 0);
      ab = ($urandom_range(0, 7) == 0) ? $urandom_range(0, ws[k]) : -1;
      xfer(k, wr, a, d, s, b, ab, rd, er);
      if ($urandom_range(0, 1) == 1) step();
    end
    xfer(2, 1, 20'h4, 32'hCAFE_F00D, 4'hF, 0, 1, rd, er);
    step();
    step();
    psel[2] = 1; pwrite[2] = 1; paddr[2] = 20'h0; pwdata[2] = 32'h5; pstrb[2] = 4'hF; busy[2] = 0;
    step();
    psel[2] = 1; penable[2] = 1;
    step();
    psel[2] = 1; penable[2] = 1;
    rst = 1;
    step();
    psel[2] = 1; penable[2] = 1;
    rst = 0;
    chk("lit_rst_regs2", 2, regs[2][31:0], 32'h0);
    chk("lit_rst_regs0", 0, regs[0][63:32], 32'h0);
    chk("lit_rst_ready", 2, 32'(pready[2]), 32'd0);
    step();
    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/apb_reg_bank.md
# apb_reg_bank

Parametrised APB4 slave register bank that holds the codec's configuration registers (CTRL, DATA_IN, CODEWORD_WIDTH, NOISE and any additional registers) and exposes them as flat outputs to the encoder/decoder core. It replaces the fixed four-register interface with a configurable register count, programmable wait states, byte strobes and error signalling. It also provides a single-cycle `start` pulse and blocks writes while the core reports `busy`.

## Interface
- AMBA_WORD, 32: data bus width; must be a multiple of 8.
- AMBA_ADDR_WIDTH, 20: PADDR width.
- NUM_REGS, 4: number of word registers, 1..16; register i sits at byte address 4*i.
- WAIT_STATES, 0: extra ACCESS cycles inserted before PREADY, 0..15.

- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- PSEL  in  1  APB select.
- PENABLE  in  1  APB enable.
- PWRITE  in  1  1 = write, 0 = read.
- PADDR  in  AMBA_ADDR_WIDTH  byte address.
- PWDATA  in  AMBA_WORD  write data.
- PSTRB  in  AMBA_WORD/8  write byte-lane enables.
- PRDATA  out  AMBA_WORD  read data; 0 when not completing a valid read.
- PREADY  out  1  transfer completes this cycle.
- PSLVERR  out  1  error; only asserted together with PREADY.
- busy  in  1  core busy; writes are refused while high.
- regs  out  NUM_REGS*AMBA_WORD  register contents, register i at bits [i*AMBA_WORD +: AMBA_WORD].
- start  out  1  one-cycle pulse after a committed write that sets CTRL bit 0.

## Operation
- FSM states are IDLE and ACCESS. The APB setup phase is the IDLE cycle with PSEL=1 and PENABLE=0; that cycle moves the FSM to ACCESS.
- On entering ACCESS, the wait counter is set to 0. It increments each ACCESS cycle while it is below WAIT_STATES.
- PREADY is combinational: PREADY = (state==ACCESS) & PSEL & PENABLE & (wait_cnt==WAIT_STATES).
- On the edge where PREADY=1, the FSM returns to IDLE. A new setup phase may follow immediately (back-to-back transfers).
- Abort: in ACCESS with PSEL=0 or PENABLE=0, the FSM returns to IDLE on the next edge. No write is committed and PREADY is not asserted.
- Address error: PADDR[1:0]!=0, or PADDR >= 4*NUM_REGS. The access completes with PSLVERR=1, no write, and PRDATA=0.
- Busy error: a write with busy=1, sampled in the PREADY cycle, completes with PSLVERR=1 and no write.
- Write commit: on the PREADY edge with no error, each byte lane b with PSTRB[b]=1 is updated from PWDATA. Other lanes keep their value. If PSTRB=0, the access is valid but nothing changes.
- Read: during the PREADY cycle with no error, PRDATA equals the addressed register. PSTRB is ignored on reads.
- `start` is registered. It is 1 in the cycle after a committed write to register 0 with PSTRB[0]=1 and PWDATA[0]=1; otherwise it is 0. CTRL bit 0 remains stored and does not self-clear.
- `regs` is driven directly from the register flops, so a committed write is visible on the following cycle.

## Timing
- Reset: state=IDLE, wait_cnt=0, all registers 0, `regs`=0, `start`=0. Combinational outputs therefore read PREADY=0, PSLVERR=0, PRDATA=0.
- Reset during ACCESS drops the transfer with no commit. Reset has priority over a simultaneous write.
- Transfer latency from setup cycle to completion is 2+WAIT_STATES cycles. With WAIT_STATES=0, the first ACCESS cycle completes.
- `busy` is sampled only in the PREADY cycle. It may change freely during wait states.
- A read of register 0 in the same transfer stream as a prior write returns the new value. Writes commit before the next setup cycle.
- `start` is never asserted for more than one consecutive cycle. Back-to-back CTRL writes each produce their own pulse, which gives a pulse every 2 cycles when WAIT_STATES=0.
- PSLVERR, PRDATA and PREADY are 0 in every cycle that is not a completing ACCESS cycle.

## Test plan
- Reset, then with WAIT_STATES=0: write 0xA5A5_0003 to 0x4, then read 0x4 -> each transfer completes in its 2nd cycle; PRDATA=0xA5A5_0003; `regs` word 1 = 0xA5A5_0003.
- WAIT_STATES=3: write 0x1 to 0x0 -> PREADY high in exactly the 5th cycle; `start`=1 for one cycle after the commit edge; CTRL=0x1.
- Write 0xFFFF_FFFF to 0x8, then write 0x1234_5678 to 0x8 with PSTRB=4'b0101 -> register reads 0xFF34_FF78.
- Access 0x10 with NUM_REGS=4, and access 0x6 -> PSLVERR=1 with PREADY, PRDATA=0, no register changed.
- Write 0xDEAD to 0xC with busy=1 -> PSLVERR=1, NOISE unchanged. Read 0xC with busy=1 -> succeeds with PSLVERR=0.
- Deassert PENABLE mid-wait (WAIT_STATES=2), then assert rst during a second ACCESS -> no write, no PREADY, FSM returns to IDLE, all outputs at reset values.
